// File: rtl/lsu_mem_port.sv
// Load/store unit for the single-cycle RV32 core: one word-addressed req/ack
// bus transaction at a time, stalling the core until it completes.
//
// Bus handshake: mem_req rises in REQ and stays high, with mem_addr, mem_we,
// mem_wdata and mem_wstrb stable, until a cycle in which mem_ack=1 is sampled
// (transfer done) or the TIMEOUT budget runs out. mem_ack is ignored whenever
// mem_req=0.
module lsu_mem_port #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        store_i,
  input  logic [2:0]  fun3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misaligned,
  output logic        illegal,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic [1:0]  lane_q, lane_d;
  logic        is_load_q, is_load_d;
  logic        err_q, err_d;
  logic [31:0] load_data_q, load_data_d;

  logic        active;
  logic        ld_fun3_ok;
  logic        st_fun3_ok;
  logic        illegal_c;
  logic        mis_raw;
  logic        accept;
  logic [31:0] wdata_c;
  logic [3:0]  wstrb_c;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ext_c;

  // Request decode: only meaningful while IDLE with a strobe present.
  always_comb begin
    active     = (state_q == IDLE) && (load_i || store_i);
    ld_fun3_ok = (fun3 != 3'b011) && (fun3 != 3'b111);
    st_fun3_ok = (fun3[2] == 1'b0) && (fun3[1:0] != 2'b11);
    illegal_c  = active && ((load_i && store_i) ||
                            (load_i && !ld_fun3_ok) ||
                            (store_i && !st_fun3_ok));
    case (fun3[1:0])
      2'b01:   mis_raw = addr[0];
      2'b10:   mis_raw = (addr[1:0] != 2'b00);
      default: mis_raw = 1'b0;
    endcase
    accept = active && !illegal_c && !mis_raw;
  end

  assign illegal    = illegal_c;
  assign misaligned = active && !illegal_c && mis_raw;

  // Store lane replication and byte enables.
  always_comb begin
    wdata_c = store_data;
    wstrb_c = 4'b1111;
    case (fun3[1:0])
      2'b00: begin
        wdata_c = {4{store_data[7:0]}};
        wstrb_c = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        wdata_c = {2{store_data[15:0]}};
        wstrb_c = 4'b0011 << {addr[1], 1'b0};
      end
      default: begin
        wdata_c = store_data;
        wstrb_c = 4'b1111;
      end
    endcase
  end

  // Load lane extraction from the acknowledged read word.
  always_comb begin
    byte_sel = mem_rdata[8*lane_q +: 8];
    half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'b00:   ext_c = {{24{sign_q & byte_sel[7]}}, byte_sel};
      2'b01:   ext_c = {{16{sign_q & half_sel[15]}}, half_sel};
      default: ext_c = mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    size_d      = size_q;
    sign_d      = sign_q;
    lane_d      = lane_q;
    is_load_d   = is_load_q;
    err_d       = err_q;
    load_data_d = load_data_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = REQ;
          cnt_d       = 8'd0;
          mem_addr_d  = {addr[31:2], 2'b00};
          mem_we_d    = store_i;
          mem_wdata_d = store_i ? wdata_c : 32'd0;
          mem_wstrb_d = store_i ? wstrb_c : 4'b0000;
          size_d      = fun3[1:0];
          sign_d      = ~fun3[2];
          lane_d      = addr[1:0];
          is_load_d   = load_i;
          err_d       = 1'b0;
        end
      end
      REQ: begin
        // An ack in the final budget cycle still wins over the timeout.
        if (mem_ack) begin
          if (is_load_q) load_data_d = ext_c;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          load_data_d = 32'd0;
          err_d       = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        state_d     = IDLE;
        mem_we_d    = 1'b0;
        mem_wstrb_d = 4'b0000;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      mem_addr_q  <= 32'd0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 32'd0;
      mem_wstrb_q <= 4'b0000;
      size_q      <= 2'b00;
      sign_q      <= 1'b0;
      lane_q      <= 2'b00;
      is_load_q   <= 1'b0;
      err_q       <= 1'b0;
      load_data_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      size_q      <= size_d;
      sign_q      <= sign_d;
      lane_q      <= lane_d;
      is_load_q   <= is_load_d;
      err_q       <= err_d;
      load_data_q <= load_data_d;
    end
  end

  // Stall is combinational so the core holds its PC in the accept cycle too.
  assign stall       = !rst && (accept || (state_q == REQ));
  assign mem_req     = (state_q == REQ);
  assign mem_addr    = mem_addr_q;
  assign mem_we      = mem_we_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_wstrb   = mem_wstrb_q;
  assign load_data   = load_data_q;
  assign load_valid  = (state_q == RESP) && is_load_q;
  assign bus_err     = (state_q == RESP) && err_q;
  assign dbg_state_o = state_q;

endmodule
